// File: rtl/serial_mag_comp_ctrl.sv
// serial_mag_comp_ctrl: bit-serial unsigned magnitude comparator controller.
// Captures two WIDTH-bit operands on an accepted start. It then walks them MSB first
// through a 1-bit compare slice, one bit per enabled clock, and reports gt/lt/eq with
// a one-cycle done pulse.
// Build option: define EARLY_EXIT_EN to end the compare on the first mismatching bit.
// Without it the compare always takes WIDTH cycles. The result is the same either way.
//
// state | meaning
// IDLE  | waiting for start with en=1
// CMP   | one operand bit compared per enabled clock
// DONE  | result published, done pulse high for one enabled cycle
module serial_mag_comp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CNT_W-1:0] cnt;
    logic             decided;
    logic             res_gt;
    logic             res_lt;

    logic slice_x;
    logic slice_y;
    logic slice_z;
    logic mismatch;
    logic finish;
    logic next_gt;
    logic next_lt;

    // Bit slice on the current MSBs, plus the first-mismatch-wins result and the end-of-compare decision.
    always_comb begin
        slice_x  = ~sa[WIDTH-1] & sb[WIDTH-1];
        slice_y  = sa[WIDTH-1] & ~sb[WIDTH-1];
        slice_z  = ~(sa[WIDTH-1] ^ sb[WIDTH-1]);
        mismatch = ~decided & ~slice_z;
        next_gt  = decided ? res_gt : slice_y;
        next_lt  = decided ? res_lt : slice_x;
`ifdef EARLY_EXIT_EN
        finish   = (cnt == '0) | mismatch;
`else
        finish   = (cnt == '0);
`endif
    end

    // Controller FSM with registered outputs. When en is low, every register holds its value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sa      <= '0;
            sb      <= '0;
            cnt     <= '0;
            decided <= 1'b0;
            res_gt  <= 1'b0;
            res_lt  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
            eq      <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa      <= a;
                        sb      <= b;
                        cnt     <= CNT_W'(WIDTH - 1);
                        decided <= 1'b0;
                        res_gt  <= 1'b0;
                        res_lt  <= 1'b0;
                        gt      <= 1'b0;
                        lt      <= 1'b0;
                        eq      <= 1'b0;
                        busy    <= 1'b1;
                        state   <= CMP;
                    end
                end
                CMP: begin
                    if (mismatch) begin
                        decided <= 1'b1;
                        res_gt  <= slice_y;
                        res_lt  <= slice_x;
                    end
                    if (finish) begin
                        gt    <= next_gt;
                        lt    <= next_lt;
                        eq    <= ~(next_gt | next_lt);
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        sa  <= sa << 1;
                        sb  <= sb << 1;
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
